// File: rtl/ex_seq_pkg.sv
// Shared types, opcode constants and op classification for the EX multi-cycle sequencer.
package ex_seq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FIX_WAIT = 2'd1,
        FP_WAIT  = 2'd2,
        FP_DRAIN = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        SINGLE = 2'd0,
        MUL    = 2'd1,
        DIV    = 2'd2,
        FP     = 2'd3
    } op_class_t;

    localparam logic [4:0] OP_MUL  = 5'h10;
    localparam logic [4:0] OP_MULH = 5'h11;
    localparam logic [4:0] OP_DIV  = 5'h12;
    localparam logic [4:0] OP_REM  = 5'h13;

    // Bit positions inside the 6-bit FP flag vector
    localparam int EXC_OVERFLOW  = 0;
    localparam int EXC_UNDERFLOW = 1;
    localparam int EXC_INEXACT   = 2;
    localparam int EXC_SNAN      = 3;
    localparam int EXC_QNAN      = 4;
    localparam int EXC_DIV_ZERO  = 5;

    function automatic op_class_t op_class(input logic [4:0] op, input logic is_fp);
        op_class_t cls;
        if (is_fp)
            cls = FP;
        else if (op == OP_MUL || op == OP_MULH)
            cls = MUL;
        else if (op == OP_DIV || op == OP_REM)
            cls = DIV;
        else
            cls = SINGLE;
        return cls;
    endfunction

endpackage

// File: rtl/ex_op_sequencer_lat_counter.sv
// Loadable 5-bit down-counter with zero flag; holds at zero.
module ex_lat_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [4:0] load_val,
    input  logic       dec,
    output logic [4:0] count,
    output logic       zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != 5'd0)
            count <= count - 5'd1;
    end

    assign zero = (count == 5'd0);

endmodule

// File: rtl/ex_op_sequencer.sv
// EX-stage multi-cycle sequencer: fixed-latency MUL/DIV hold and FP start/done handshake.
// Optional sticky FP flag accumulator enabled by EX_FP_EXC_STICKY_EN.
//
// state    | meaning
// IDLE     | no multi-cycle op in flight; single-cycle ops pass through
// FIX_WAIT | MUL/DIV counting down its fixed latency
// FP_WAIT  | FP op issued, waiting for fpu_done
// FP_DRAIN | FP op squashed, waiting for the FPU to finish before reuse
module ex_op_sequencer
    import ex_seq_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue_valid,
    input  logic       issue_is_nop,
    input  logic [4:0] issue_op,
    input  logic       issue_is_fp,
    input  logic       flush,
    input  logic       fpu_done,
    input  logic [5:0] fpu_exc_in,
`ifdef EX_FP_EXC_STICKY_EN
    input  logic       fp_exc_clr,
    output logic [5:0] fp_exc_sticky,
`endif
    output logic       stall_ex,
    output logic       mc_done,
    output logic       busy,
    output logic       fpu_start,
    output logic [4:0] fpu_op,
    output logic [5:0] fp_exc
);

    seq_state_t state, state_nx;
    op_class_t  cls;
    logic       accept;
    logic       fp_accept;
    logic       fp_commit;
    logic       cnt_load;
    logic       cnt_dec;
    logic [4:0] cnt_load_val;
    logic [4:0] cnt;
    logic       cnt_zero;

    assign cls    = op_class(issue_op, issue_is_fp);
    assign accept = (state == IDLE) && issue_valid && !issue_is_nop && !flush;
    assign busy   = (state != IDLE);

    ex_lat_counter u_lat_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        stall_ex     = 1'b0;
        mc_done      = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        fp_accept    = 1'b0;
        fp_commit    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (cls)
                        MUL: begin
                            state_nx     = FIX_WAIT;
                            stall_ex     = 1'b1;
                            cnt_load     = 1'b1;
                            cnt_load_val = 5'(MUL_LAT - 2);
                        end
                        DIV: begin
                            state_nx     = FIX_WAIT;
                            stall_ex     = 1'b1;
                            cnt_load     = 1'b1;
                            cnt_load_val = 5'(DIV_LAT - 2);
                        end
                        FP: begin
                            state_nx  = FP_WAIT;
                            stall_ex  = 1'b1;
                            fp_accept = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            FIX_WAIT: begin
                if (flush) begin
                    state_nx = IDLE;
                end else if (cnt_zero) begin
                    state_nx = IDLE;
                    mc_done  = 1'b1;
                end else begin
                    stall_ex = 1'b1;
                    cnt_dec  = 1'b1;
                end
            end
            FP_WAIT: begin
                if (flush) begin
                    // A result arriving with the flush is simply discarded
                    state_nx = fpu_done ? IDLE : FP_DRAIN;
                    stall_ex = !fpu_done;
                end else if (fpu_done) begin
                    state_nx  = IDLE;
                    mc_done   = 1'b1;
                    fp_commit = 1'b1;
                end else begin
                    stall_ex = 1'b1;
                end
            end
            FP_DRAIN: begin
                if (fpu_done)
                    state_nx = IDLE;
                else
                    stall_ex = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpu_start <= 1'b0;
            fpu_op    <= '0;
            fp_exc    <= '0;
        end else begin
            fpu_start <= fp_accept;
            if (fp_accept)
                fpu_op <= issue_op;
            if (fp_commit)
                fp_exc <= fpu_exc_in;
        end
    end

`ifdef EX_FP_EXC_STICKY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fp_exc_sticky <= '0;
        else if (fp_commit)
            fp_exc_sticky <= (fp_exc_clr ? 6'd0 : fp_exc_sticky) | fpu_exc_in;
        else if (fp_exc_clr)
            fp_exc_sticky <= '0;
    end
`endif

endmodule

// File: tb/tb_ex_op_sequencer.sv
// Directed self-checking bench for ex_op_sequencer (MUL_LAT=4, DIV_LAT=8).
module tb_ex_op_sequencer;

    logic       clk;
    logic       rst_n;
    logic       issue_valid;
    logic       issue_is_nop;
    logic [4:0] issue_op;
    logic       issue_is_fp;
    logic       flush;
    logic       fpu_done;
    logic [5:0] fpu_exc_in;
    logic       stall_ex;
    logic       mc_done;
    logic       busy;
    logic       fpu_start;
    logic [4:0] fpu_op;
    logic [5:0] fp_exc;
`ifdef EX_FP_EXC_STICKY_EN
    logic       fp_exc_clr;
    logic [5:0] fp_exc_sticky;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ex_op_sequencer #(.MUL_LAT(4), .DIV_LAT(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_is_nop (issue_is_nop),
        .issue_op     (issue_op),
        .issue_is_fp  (issue_is_fp),
        .flush        (flush),
        .fpu_done     (fpu_done),
        .fpu_exc_in   (fpu_exc_in),
`ifdef EX_FP_EXC_STICKY_EN
        .fp_exc_clr   (fp_exc_clr),
        .fp_exc_sticky(fp_exc_sticky),
`endif
        .stall_ex     (stall_ex),
        .mc_done      (mc_done),
        .busy         (busy),
        .fpu_start    (fpu_start),
        .fpu_op       (fpu_op),
        .fp_exc       (fp_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample combinational outputs mid-cycle
    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        issue_valid  = 1'b0;
        issue_is_nop = 1'b0;
        issue_op     = 5'h00;
        issue_is_fp  = 1'b0;
        flush        = 1'b0;
        fpu_done     = 1'b0;
        fpu_exc_in   = 6'h00;
    endtask

    task automatic issue(input logic [4:0] op, input logic is_fp);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_is_fp = is_fp;
    endtask

    // Full FP op with completion after (done_at) cycles, used for flag accumulation
    task automatic fp_round(input logic [4:0] op, input logic [5:0] exc, input int done_at);
        issue(op, 1'b1);
        for (int c = 1; c <= done_at; c++) begin
            tick();
            if (c == done_at) begin
                fpu_done   = 1'b1;
                fpu_exc_in = exc;
            end
        end
        settle();
        chk("fp_round_mc_done", mc_done, 1);
        tick();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
`ifdef EX_FP_EXC_STICKY_EN
        fp_exc_clr = 1'b0;
`endif
        rst_n = 1'b0;
        #12;
        chk("rst_stall", stall_ex, 0);
        chk("rst_mc_done", mc_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fpu_start", fpu_start, 0);
        chk("rst_fpu_op", fpu_op, 0);
        chk("rst_fp_exc", fp_exc, 0);
        rst_n = 1'b1;
        tick();

        // Single-cycle ADD passes without stalling
        issue(5'h00, 1'b0);
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("add_stall", stall_ex, 0);
            chk("add_mc_done", mc_done, 0);
            chk("add_busy", busy, 0);
            tick();
        end
        // NOP-flagged MUL is ignored
        issue(5'h10, 1'b0);
        issue_is_nop = 1'b1;
        settle();
        chk("nop_stall", stall_ex, 0);
        tick();
        chk("nop_busy", busy, 0);
        issue_is_nop = 1'b0;

        // MUL accepted at T0: stall T0..T2, mc_done at T3
        for (int c = 0; c < 4; c++) begin
            settle();
            chk($sformatf("mul_stall_T%0d", c), stall_ex, (c < 3) ? 1 : 0);
            chk($sformatf("mul_done_T%0d", c), mc_done, (c == 3) ? 1 : 0);
            tick();
        end

        // Back-to-back: DIV accepted in the cycle after mc_done, flushed at T3
        issue(5'h12, 1'b0);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) flush = 1'b1;
            settle();
            chk($sformatf("divfl_stall_T%0d", c), stall_ex, (c < 3) ? 1 : 0);
            chk($sformatf("divfl_done_T%0d", c), mc_done, 0);
            tick();
        end
        idle_inputs();
        settle();
        chk("divfl_busy_T4", busy, 0);
        chk("divfl_stall_T4", stall_ex, 0);
        tick();

        // Full DIV (DIV_LAT=8): stall T0..T6, mc_done at T7
        issue(5'h13, 1'b0);
        for (int c = 0; c < 8; c++) begin
            settle();
            chk($sformatf("div_stall_T%0d", c), stall_ex, (c < 7) ? 1 : 0);
            chk($sformatf("div_done_T%0d", c), mc_done, (c == 7) ? 1 : 0);
            tick();
        end
        idle_inputs();
        settle();
        chk("div_busy_after", busy, 0);
        tick();

        // FP handshake: start at T1 only, done at T6
        issue(5'h05, 1'b1);
        for (int c = 0; c < 7; c++) begin
            if (c == 6) begin
                fpu_done   = 1'b1;
                fpu_exc_in = 6'b100000;
            end
            settle();
            chk($sformatf("fp_start_T%0d", c), fpu_start, (c == 1) ? 1 : 0);
            chk($sformatf("fp_stall_T%0d", c), stall_ex, (c < 6) ? 1 : 0);
            chk($sformatf("fp_done_T%0d", c), mc_done, (c == 6) ? 1 : 0);
            if (c == 1) chk("fp_op_T1", fpu_op, 5'h05);
            tick();
        end
        idle_inputs();
        settle();
        chk("fp_exc_T7", fp_exc, 6'b100000);
        chk("fp_busy_T7", busy, 0);
        tick();

        // FP flush at T2, drain until fpu_done at T5
        issue(5'h07, 1'b1);
        for (int c = 0; c < 6; c++) begin
            flush      = (c == 2);
            fpu_done   = (c == 5);
            fpu_exc_in = (c == 5) ? 6'h3f : 6'h00;
            settle();
            chk($sformatf("drain_stall_T%0d", c), stall_ex, (c < 5) ? 1 : 0);
            chk($sformatf("drain_done_T%0d", c), mc_done, 0);
            if (c == 3) chk("drain_busy_T3", busy, 1);
            tick();
        end
        idle_inputs();
        settle();
        chk("drain_fp_exc", fp_exc, 6'b100000);
        chk("drain_busy_T6", busy, 0);
        tick();

        // flush and fpu_done together in FP_WAIT
        issue(5'h08, 1'b1);
        tick();
        flush      = 1'b1;
        fpu_done   = 1'b1;
        fpu_exc_in = 6'h01;
        settle();
        chk("flushdone_stall", stall_ex, 0);
        chk("flushdone_mc_done", mc_done, 0);
        tick();
        idle_inputs();
        settle();
        chk("flushdone_busy", busy, 0);
        chk("flushdone_fp_exc", fp_exc, 6'b100000);
        tick();

        // Asynchronous reset in FP_WAIT at T3
        issue(5'h09, 1'b1);
        tick();
        tick();
        tick();
        settle();
        chk("prerst_busy", busy, 1);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("arst_stall", stall_ex, 0);
        chk("arst_mc_done", mc_done, 0);
        chk("arst_busy", busy, 0);
        chk("arst_fpu_start", fpu_start, 0);
        chk("arst_fpu_op", fpu_op, 0);
        chk("arst_fp_exc", fp_exc, 0);
        tick();
        rst_n = 1'b1;
        tick();
        fpu_done   = 1'b1;
        fpu_exc_in = 6'h2a;
        settle();
        chk("late_done_mc_done", mc_done, 0);
        tick();
        idle_inputs();
        settle();
        chk("late_done_fp_exc", fp_exc, 0);
        chk("late_done_busy", busy, 0);
        chk("late_done_fpu_start", fpu_start, 0);
        tick();

`ifdef EX_FP_EXC_STICKY_EN
        fp_round(5'h01, 6'h01, 2);
        fp_round(5'h02, 6'h04, 3);
        settle();
        chk("sticky_or", fp_exc_sticky, 6'h05);
        chk("sticky_last", fp_exc, 6'h04);
        fp_exc_clr = 1'b1;
        tick();
        fp_exc_clr = 1'b0;
        settle();
        chk("sticky_clr", fp_exc_sticky, 6'h00);
        tick();
`else
        fp_round(5'h01, 6'h01, 2);
        settle();
        chk("fp_round_exc", fp_exc, 6'h01);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ex_op_sequencer.md
# ex_op_sequencer

Sequencer for the EX stage that handles multi-cycle operations. It classifies the operation presented to EX and lets single-cycle ALU ops pass without stalling. It holds the pipeline for a fixed number of cycles on integer multiply/divide, and runs a start/done handshake with the floating-point ALU for FP ops. It sits beside EX and drives the global stall and completion signals.

## Interface
Parameters:
- MUL_LAT, 4: total EX occupancy in cycles for multiply-class ops; legal range 2 to 31.
- DIV_LAT, 8: total EX occupancy in cycles for divide-class ops; legal range 2 to 31.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  an instruction occupies EX this cycle.
- issue_is_nop  in  1  the EX instruction is a bubble. The sequencer ignores it.
- issue_op  in  5  ALU_OP of the EX instruction.
- issue_is_fp  in  1  the op targets the floating-point ALU.
- flush  in  1  squash the instruction currently in EX.
- fpu_done  in  1  the FP ALU result is valid. Single-cycle pulse.
- fpu_exc_in  in  6  FP flags {division_by_zero, QNaN, SNaN, inexact, underflow, overflow}. Valid with fpu_done.
- stall_ex  out  1  freeze IF/ID/EX and the EX input registers.
- mc_done  out  1  multi-cycle result is valid this cycle.
- busy  out  1  state is not IDLE.
- fpu_start  out  1  one-cycle start pulse to the FP ALU.
- fpu_op  out  5  ALU_OP latched for the FP ALU.
- fp_exc  out  6  flags of the last completed FP op.

## Operation
- Op class comes from the package function op_class(issue_op, issue_is_fp):
  - FP if issue_is_fp is set.
  - MUL if issue_op is 5'h10 or 5'h11.
  - DIV if issue_op is 5'h12 or 5'h13.
  - SINGLE otherwise.
- Accept condition: state IDLE, issue_valid=1, issue_is_nop=0, flush=0.
- SINGLE: no state change. stall_ex and mc_done stay 0.
- States and transitions:
  - IDLE goes to FIX_WAIT on accepting a MUL or DIV op. It loads an internal down-counter with LAT-2. LAT is MUL_LAT or DIV_LAT.
  - IDLE goes to FP_WAIT on accepting an FP op. It latches issue_op into fpu_op.
  - FIX_WAIT goes to IDLE when the counter is 0 or flush=1. Otherwise the counter decrements.
  - FP_WAIT goes to IDLE on fpu_done. It goes to FP_DRAIN on flush without fpu_done.
  - FP_DRAIN goes to IDLE on fpu_done.
- stall_ex equals:
  - the accept of a MUL/DIV/FP op, OR
  - FIX_WAIT with a nonzero counter and no flush, OR
  - FP_WAIT without fpu_done and without flush, OR
  - FP_DRAIN without fpu_done.
- mc_done equals:
  - FIX_WAIT with counter 0 and no flush, OR
  - FP_WAIT with fpu_done and no flush.
- fp_exc loads fpu_exc_in when mc_done fires for an FP op. It holds otherwise. Flushed or drained results never update it.
- fpu_done is ignored in IDLE and FIX_WAIT.
- issue_valid is ignored in every non-IDLE state. The pipeline is stalled, so the same instruction is re-presented.

## Timing
- Reset values: state IDLE, counter 0, and every output 0 (stall_ex, mc_done, busy, fpu_start, fpu_op, fp_exc).
- Reset mid-operation aborts immediately. No mc_done or fpu_start follows. The FP ALU is reset by the same rst_n.
- MUL/DIV accepted in cycle T0:
  - stall_ex=1 in cycles T0 through T0+LAT-2.
  - In cycle T0+LAT-1: stall_ex=0 and mc_done=1, then back to IDLE.
- FP accepted in cycle T0:
  - stall_ex=1 from T0 on.
  - fpu_start=1 only in cycle T0+1 (registered).
  - In the fpu_done cycle: stall_ex=0, mc_done=1, fp_exc updates at the following edge.
- Flush in FIX_WAIT: stall_ex=0 in the flush cycle, no mc_done, IDLE next cycle.
- Flush in FP_WAIT: stall stays high through FP_DRAIN. It drops in the fpu_done cycle, with mc_done=0.
- flush and fpu_done in the same cycle in FP_WAIT: no mc_done, IDLE next cycle.
- Back-to-back multi-cycle ops are supported. The next op is accepted in the cycle after mc_done.

## Configuration
- Macro: EX_FP_EXC_STICKY_EN.
- When defined, two ports are added:
  - fp_exc_sticky, out, 6 bits: OR-accumulates fpu_exc_in on every FP mc_done. Resets to 0.
  - fp_exc_clr, in, 1: clears the register. A set on the same cycle as a clear wins.
- When undefined, both ports and the register are absent.

## Structure
- Package ex_seq_pkg holds:
  - state enum {IDLE, FIX_WAIT, FP_WAIT, FP_DRAIN};
  - op-class enum {SINGLE, MUL, DIV, FP};
  - the opcode constants 5'h10 to 5'h13;
  - the op_class function;
  - the FP flag bit-index constants.
- Sub-module ex_lat_counter: a loadable down-counter with a zero flag, 5 bits wide.

## Test plan
- Single-cycle op: ADD op 5'h00 with issue_valid=1 → stall_ex stays 0, mc_done stays 0, busy stays 0.
- MUL with MUL_LAT=4: op 5'h10 accepted at T0 → stall_ex=1 at T0–T2, mc_done=1 and stall_ex=0 at T3.
- DIV flushed: op 5'h12 accepted at T0, flush at T3 → stall_ex=0 at T3, mc_done never asserts, busy=0 at T4.
- FP handshake: FP op 5'h05 at T0 → fpu_start=1 only at T1 with fpu_op=5'h05. fpu_done at T6 with fpu_exc_in=6'b100000 → mc_done=1 at T6, fp_exc=6'b100000 at T7.
- FP flush and drain: flush at T2, fpu_done at T5 → stall_ex=1 for T0–T4, mc_done=0 throughout, fp_exc unchanged.
- Reset mid-FP_WAIT: rst_n low at T3 → all outputs 0 asynchronously. A later fpu_done is ignored. With EX_FP_EXC_STICKY_EN defined, two FP completions with flags 6'h01 and 6'h04 → fp_exc_sticky=6'h05.
